// File: rtl/proc_pkg.sv
// ============================================================================
// Module : proc_pkg
// Brief  : Opcodes, FSM state encoding and instruction field positions shared
//          by the processor controller and its ALU. Macro: PROC_MULHI_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package proc_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_LDI  = 4'd4;
  localparam logic [3:0] OP_MULH = 4'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 26;
  localparam int RS1_MSB = 25;
  localparam int RS1_LSB = 24;
  localparam int RS2_MSB = 23;
  localparam int RS2_LSB = 22;
  localparam int IMM_LSB = 0;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_LDI: ok = 1'b1;
`ifdef PROC_MULHI_EN
      OP_MULH:                                ok = 1'b1;
`endif
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic op_is_mul(input logic [3:0] op);
    logic m;
    m = (op == OP_MUL);
`ifdef PROC_MULHI_EN
    m = m | (op == OP_MULH);
`endif
    return m;
  endfunction

  // NOP and undefined opcodes complete without touching the register file
  function automatic logic op_writes(input logic [3:0] op);
    return op_legal(op) && (op != OP_NOP);
  endfunction

endpackage : proc_pkg

`default_nettype wire

// File: rtl/processor_ctrl_if.sv
// ============================================================================
// Module : processor_ctrl_if
// Brief  : Instruction handshake plus register-file control/data bundle.
//          master = instruction source / regfile side, slave = controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface processor_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        rf_write;
  logic [4:0]  rf_address;
  logic [4:0]  rf_src1;
  logic [4:0]  rf_src2;
  logic [31:0] rf_data_in;
  logic [31:0] rf_data_out1;
  logic [31:0] rf_data_out2;

  modport master (
    output instr_valid, instr, rf_data_out1, rf_data_out2,
    input  instr_ready, rf_write, rf_address, rf_src1, rf_src2, rf_data_in
  );

  modport slave (
    input  instr_valid, instr, rf_data_out1, rf_data_out2,
    output instr_ready, rf_write, rf_address, rf_src1, rf_src2, rf_data_in
  );
endinterface : processor_ctrl_if

`default_nettype wire

// File: rtl/proc_alu.sv
// ============================================================================
// Module : proc_alu
// Brief  : Combinational ADD/SUB/MUL/LDI datapath with carry/borrow output.
//          Macro: PROC_MULHI_EN adds MULH (upper product half).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module proc_alu
  import proc_pkg::*;
#(
  parameter int IMM_W = 16
) (
  input  wire logic [3:0]       opcode,
  input  wire logic [31:0]      a,
  input  wire logic [31:0]      b,
  input  wire logic [IMM_W-1:0] imm,
  output logic      [31:0]      result,
  output logic                  carry
);

  logic [32:0] w_sum;
  logic [32:0] w_diff;
`ifdef PROC_MULHI_EN
  logic [63:0] w_prod;
  assign w_prod = {32'd0, a} * {32'd0, b};
`else
  logic [31:0] w_prod;
  assign w_prod = a * b;
`endif

  assign w_sum  = {1'b0, a} + {1'b0, b};
  // Bit 32 of the 33-bit difference is the borrow
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = 32'd0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = w_sum[31:0];
        carry  = w_sum[32];
      end
      OP_SUB: begin
        result = w_diff[31:0];
        carry  = w_diff[32];
      end
      OP_MUL:  result = w_prod[31:0];
      OP_LDI:  result = 32'(imm);
`ifdef PROC_MULHI_EN
      OP_MULH: result = w_prod[63:32];
`endif
      default: begin
        result = 32'd0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule : proc_alu

`default_nettype wire

// File: rtl/processor_ctrl.sv
// ============================================================================
// Module : processor_ctrl
// Brief  : IDLE->READ->EXEC->WB sequencer driving a 4x32 register file.
//          Macro: PROC_MULHI_EN enables opcode 5 (MULH).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module processor_ctrl
  import proc_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int IMM_W   = 16
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  processor_ctrl_if.slave bus,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic            carry
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] C_MUL_LOAD = CNT_W'(MUL_LAT - 1);

  state_t             r_state;
  logic [3:0]         r_opcode;
  logic [IMM_W-1:0]   r_imm;
  logic [31:0]        r_op_a;
  logic [31:0]        r_op_b;
  logic [31:0]        r_result;
  logic [CNT_W-1:0]   r_cnt;

  logic [31:0]        w_alu_result;
  logic               w_alu_carry;

  proc_alu #(
    .IMM_W (IMM_W)
  ) u_alu (
    .opcode (r_opcode),
    .a      (r_op_a),
    .b      (r_op_b),
    .imm    (r_imm),
    .result (w_alu_result),
    .carry  (w_alu_carry)
  );

  assign bus.rf_data_in = bus.rf_write ? r_result : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_opcode        <= 4'd0;
      r_imm           <= '0;
      r_op_a          <= 32'd0;
      r_op_b          <= 32'd0;
      r_result        <= 32'd0;
      r_cnt           <= '0;
      bus.instr_ready <= 1'b1;
      bus.rf_write    <= 1'b0;
      bus.rf_address  <= 5'd0;
      bus.rf_src1     <= 5'd0;
      bus.rf_src2     <= 5'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      illegal         <= 1'b0;
      carry           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            r_opcode        <= bus.instr[OPC_MSB:OPC_LSB];
            r_imm           <= bus.instr[IMM_LSB +: IMM_W];
            bus.rf_src1     <= {3'b000, bus.instr[RS1_MSB:RS1_LSB]};
            bus.rf_src2     <= {3'b000, bus.instr[RS2_MSB:RS2_LSB]};
            bus.rf_address  <= {3'b000, bus.instr[RD_MSB:RD_LSB]};
            bus.instr_ready <= 1'b0;
            busy            <= 1'b1;
            r_state         <= S_READ;
          end
        end

        S_READ: begin
          r_op_a  <= bus.rf_data_out1;
          r_op_b  <= bus.rf_data_out2;
          r_cnt   <= op_is_mul(r_opcode) ? C_MUL_LOAD : '0;
          r_state <= S_EXEC;
        end

        S_EXEC: begin
          if (r_cnt == '0) begin
            r_result     <= w_alu_result;
            bus.rf_write <= op_writes(r_opcode);
            done         <= 1'b1;
            illegal      <= ~op_legal(r_opcode);
            if ((r_opcode == OP_ADD) || (r_opcode == OP_SUB)) begin
              carry <= w_alu_carry;
            end
            r_state      <= S_WB;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_WB: begin
          bus.rf_write    <= 1'b0;
          done            <= 1'b0;
          illegal         <= 1'b0;
          bus.instr_ready <= 1'b1;
          busy            <= 1'b0;
          r_state         <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule : processor_ctrl

`default_nettype wire

// File: tb/tb_processor_ctrl.sv
// ============================================================================
// Module : tb_processor_ctrl
// Brief  : Directed vector table plus hand-written back-to-back and
//          mid-operation reset sequences against a behavioural register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_processor_ctrl;

  localparam int MUL_LAT = 3;
  localparam int L_ALU   = 3;
  localparam int L_MUL   = 2 + MUL_LAT;
  localparam int NV      = 14;

  logic clk;
  logic reset_n;
  logic busy, done, illegal, carry;

  processor_ctrl_if bus ();

  processor_ctrl #(
    .MUL_LAT (MUL_LAT),
    .IMM_W   (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .busy    (busy),
    .done    (done),
    .illegal (illegal),
    .carry   (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file with a side port for preloading
  logic [31:0] rf [4];
  logic        rf_init;
  logic        tb_we;
  logic [1:0]  tb_wa;
  logic [31:0] tb_wd;

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 4; i++) rf[i] <= 32'd0;
    end else if (bus.rf_write) begin
      rf[bus.rf_address[1:0]] <= bus.rf_data_in;
    end else if (tb_we) begin
      rf[tb_wa] <= tb_wd;
    end
  end

  assign bus.rf_data_out1 = rf[bus.rf_src1[1:0]];
  assign bus.rf_data_out2 = rf[bus.rf_src2[1:0]];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, 6'b000000, imm};
  endfunction

  task automatic preload(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic do_instr(input logic [31:0] ins, input int exp_lat, input logic exp_wr,
                          input logic exp_ill, input logic exp_cy, input logic [31:0] exp_val);
    int          n;
    int          lat;
    logic        s_wr, s_ill, s_cy;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic [1:0]  rd;
    rd  = ins[27:26];
    lat = 0;
    s_wr = 1'b0; s_ill = 1'b0; s_cy = 1'b0; s_addr = 5'd0; s_data = 32'd0;
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 64'(bus.instr_ready), 64'(1));
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("read_src1", 64'(bus.rf_src1), 64'({3'b000, ins[25:24]}));
        chk("read_src2", 64'(bus.rf_src2), 64'({3'b000, ins[23:22]}));
        chk("busy_read", 64'(busy), 64'(1));
      end
      if (done) begin
        lat    = c;
        s_wr   = bus.rf_write;
        s_ill  = illegal;
        s_cy   = carry;
        s_addr = bus.rf_address;
        s_data = bus.rf_data_in;
      end
    end
    chk("done_latency", 64'(lat), 64'(exp_lat));
    chk("wb_write", 64'(s_wr), 64'(exp_wr));
    chk("wb_illegal", 64'(s_ill), 64'(exp_ill));
    chk("wb_carry", 64'(s_cy), 64'(exp_cy));
    chk("wb_data", 64'(s_data), exp_wr ? 64'(exp_val) : 64'(0));
    if (exp_wr) chk("wb_addr", 64'(s_addr), 64'({3'b000, rd}));
    @(posedge clk);
    #1;
    chk("rf_value", 64'(rf[rd]), 64'(exp_val));
    chk("ready_after", 64'(bus.instr_ready), 64'(1));
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        pa_en;
    logic [31:0] pda;
    logic        pb_en;
    logic [31:0] pdb;
    int          lat;
    logic        wr;
    logic        ill;
    logic        cy;
    logic [31:0] val;
  } vec_t;

  vec_t vt [NV];

  initial begin
    int acc [3];
    int n_acc, n_wr, n_low, wr_seen;

    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    tb_we   = 1'b0;
    tb_wa   = 2'd0;
    tb_wd   = 32'd0;
    rf_init = 1'b1;
    reset_n = 1'b0;

    // preloads go to r1 (pa) and r2 (pb)
    vt[0]  = '{enc(OP_LDI_C(), 2'd1, 2'd0, 2'd0, 16'h0005), 1'b0, 32'h0, 1'b0, 32'h0, L_ALU, 1'b1, 1'b0, 1'b0, 32'h0000_0005};
    vt[1]  = '{enc(4'd4, 2'd2, 2'd3, 2'd1, 16'h0003), 1'b0, 32'h0, 1'b0, 32'h0, L_ALU, 1'b1, 1'b0, 1'b0, 32'h0000_0003};
    vt[2]  = '{enc(4'd1, 2'd3, 2'd1, 2'd2, 16'h0000), 1'b0, 32'h0, 1'b0, 32'h0, L_ALU, 1'b1, 1'b0, 1'b0, 32'h0000_0008};
    vt[3]  = '{enc(4'd4, 2'd2, 2'd0, 2'd0, 16'h0001), 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, L_ALU, 1'b1, 1'b0, 1'b0, 32'h0000_0001};
    vt[4]  = '{enc(4'd1, 2'd0, 2'd1, 2'd2, 16'h0000), 1'b0, 32'h0, 1'b0, 32'h0, L_ALU, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
    vt[5]  = '{enc(4'd2, 2'd0, 2'd2, 2'd1, 16'h0000), 1'b0, 32'h0, 1'b0, 32'h0, L_ALU, 1'b1, 1'b0, 1'b1, 32'h0000_0002};
    vt[6]  = '{enc(4'd3, 2'd3, 2'd1, 2'd2, 16'h0000), 1'b1, 32'h0001_0000, 1'b1, 32'h0001_0000, L_MUL, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
`ifdef PROC_MULHI_EN
    vt[7]  = '{enc(4'd5, 2'd3, 2'd1, 2'd2, 16'h0000), 1'b0, 32'h0, 1'b0, 32'h0, L_MUL, 1'b1, 1'b0, 1'b1, 32'h0000_0001};
`else
    vt[7]  = '{enc(4'd5, 2'd3, 2'd1, 2'd2, 16'h0000), 1'b0, 32'h0, 1'b0, 32'h0, L_ALU, 1'b0, 1'b1, 1'b1, 32'h0000_0000};
`endif
    vt[8]  = '{enc(4'hF, 2'd2, 2'd1, 2'd1, 16'h1234), 1'b0, 32'h0, 1'b0, 32'h0, L_ALU, 1'b0, 1'b1, 1'b1, 32'h0001_0000};
    vt[9]  = '{enc(4'd0, 2'd1, 2'd2, 2'd2, 16'h0000), 1'b0, 32'h0, 1'b0, 32'h0, L_ALU, 1'b0, 1'b0, 1'b1, 32'h0001_0000};
    vt[10] = '{enc(4'd3, 2'd0, 2'd1, 2'd2, 16'h0000), 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0002, L_MUL, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE};
    vt[11] = '{enc(4'd1, 2'd1, 2'd1, 2'd1, 16'h0000), 1'b1, 32'h8000_0001, 1'b0, 32'h0, L_ALU, 1'b1, 1'b0, 1'b1, 32'h0000_0002};
    vt[12] = '{enc(4'd2, 2'd0, 2'd1, 2'd2, 16'h0000), 1'b1, 32'h0000_000A, 1'b1, 32'h0000_0003, L_ALU, 1'b1, 1'b0, 1'b0, 32'h0000_0007};
    vt[13] = '{enc(4'd4, 2'd3, 2'd2, 2'd1, 16'hFFFF), 1'b0, 32'h0, 1'b0, 32'h0, L_ALU, 1'b1, 1'b0, 1'b0, 32'h0000_FFFF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.instr_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_illegal", 64'(illegal), 64'(0));
    chk("rst_carry", 64'(carry), 64'(0));
    chk("rst_write", 64'(bus.rf_write), 64'(0));
    chk("rst_sel", 64'({bus.rf_address, bus.rf_src1, bus.rf_src2}), 64'(0));
    chk("rst_data", 64'(bus.rf_data_in), 64'(0));
    @(negedge clk);
    rf_init = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      if (vt[i].pa_en) preload(2'd1, vt[i].pda);
      if (vt[i].pb_en) preload(2'd2, vt[i].pdb);
      do_instr(vt[i].ins, vt[i].lat, vt[i].wr, vt[i].ill, vt[i].cy, vt[i].val);
    end

    // Back-to-back ADDs with instr_valid held high: r1=10, r2=3
    preload(2'd1, 32'h0000_000A);
    preload(2'd2, 32'h0000_0003);
    bus.instr       = enc(4'd1, 2'd3, 2'd1, 2'd2, 16'h0000);
    bus.instr_valid = 1'b1;
    n_acc = 0; n_wr = 0; n_low = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.instr_ready) begin
        if (n_acc < 3) acc[n_acc] = c;
        n_acc++;
      end else begin
        n_low++;
      end
      if (bus.rf_write) n_wr++;
    end
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_accepts", 64'(n_acc), 64'(3));
    chk("b2b_writes", 64'(n_wr), 64'(3));
    chk("b2b_ready_low", 64'(n_low), 64'(9));
    chk("b2b_gap1", 64'(acc[1] - acc[0]), 64'(4));
    chk("b2b_gap2", 64'(acc[2] - acc[1]), 64'(4));
    chk("b2b_r3", 64'(rf[3]), 64'(32'h0000_000D));
    #20;

    // Borrow so that carry is 1 going into the reset sequence
    do_instr(enc(4'd2, 2'd0, 2'd2, 2'd1, 16'h0000), L_ALU, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9);

    // Reset asserted in the first EXEC cycle of a MUL
    bus.instr       = enc(4'd3, 2'd3, 2'd1, 2'd2, 16'h0000);
    bus.instr_valid = 1'b1;
    @(negedge clk);
    chk("mr_ready", 64'(bus.instr_ready), 64'(1));
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mr_busy_exec", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("mr_ready_now", 64'(bus.instr_ready), 64'(1));
    chk("mr_busy", 64'(busy), 64'(0));
    chk("mr_write", 64'(bus.rf_write), 64'(0));
    chk("mr_carry", 64'(carry), 64'(0));
    chk("mr_done", 64'(done), 64'(0));
    wr_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) reset_n = 1'b1;
      if (bus.rf_write) wr_seen++;
    end
    chk("mr_no_write", 64'(wr_seen), 64'(0));
    chk("mr_r3_kept", 64'(rf[3]), 64'(32'h0000_000D));
    chk("mr_idle_ready", 64'(bus.instr_ready), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [3:0] OP_LDI_C();
    return 4'd4;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_processor_ctrl

`default_nettype wire
